// File: rtl/sensor_conditioner.sv
// Input conditioning ahead of homeSystem: synchronize and debounce the door/window/fire
// sensors, and sample and average the temperature so heater/cooler decisions stay steady.
module sensor_conditioner #(
  parameter int DEB_CYCLES = 4,
  parameter int SAMPLE_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_fd,
  input  logic       raw_rd,
  input  logic       raw_w,
  input  logic       raw_fa,
  input  logic [6:0] raw_st,
  output logic       sfd,
  output logic       srd,
  output logic       sw,
  output logic       sfa,
  output logic [6:0] st,
  output logic       st_valid,
  output logic       evt
);

  localparam logic [7:0] DEB_TC  = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] DIV_TC  = 8'(SAMPLE_DIV - 1);
  localparam logic [6:0] ST_RST  = 7'd55;
  localparam int         FA      = 3;

  // Binary sensors are packed as {fa, w, rd, fd}
  logic [3:0] r_sync1, r_sync2;
  logic [3:0] r_out;
  logic [7:0] r_cnt [4];
  logic       r_evt;

  logic [3:0] w_out_nxt;
  logic [7:0] w_cnt_nxt [4];

  logic [6:0] r_st_s1, r_st_s2;
  logic [7:0] r_div;
  logic       r_tick_d;
  logic [6:0] r_buf [4];
  logic [2:0] r_fill;
  logic [6:0] r_st;
  logic       r_st_valid;

  logic       w_tick;
  logic [8:0] w_sum;
  logic [6:0] w_avg;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_out_nxt[i] = r_out[i];
      w_cnt_nxt[i] = r_cnt[i];
      if (r_sync2[i] == r_out[i]) begin
        w_cnt_nxt[i] = 8'd0;
      end else if (i == FA && r_sync2[i]) begin
        // Fire alarm asserts without waiting out the debounce window
        w_out_nxt[i] = 1'b1;
        w_cnt_nxt[i] = 8'd0;
      end else if (r_cnt[i] == DEB_TC) begin
        w_out_nxt[i] = r_sync2[i];
        w_cnt_nxt[i] = 8'd0;
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + 8'd1;
      end
    end
  end

  assign w_tick = (r_div == DIV_TC);
  assign w_sum  = 9'(r_buf[0]) + 9'(r_buf[1]) + 9'(r_buf[2]) + 9'(r_buf[3]);
  assign w_avg  = 7'(w_sum >> 2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_out      <= '0;
      r_evt      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
        r_buf[i] <= '0;
      end
      r_st_s1    <= '0;
      r_st_s2    <= '0;
      r_div      <= '0;
      r_tick_d   <= 1'b0;
      r_fill     <= '0;
      r_st       <= ST_RST;
      r_st_valid <= 1'b0;
    end else begin
      r_sync1 <= {raw_fa, raw_w, raw_rd, raw_fd};
      r_sync2 <= r_sync1;
      r_out   <= w_out_nxt;
      r_evt   <= (w_out_nxt != r_out);
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end

      r_st_s1  <= raw_st;
      r_st_s2  <= r_st_s1;
      r_div    <= w_tick ? 8'd0 : r_div + 8'd1;
      r_tick_d <= w_tick;
      if (w_tick) begin
        r_buf[0] <= r_st_s2;
        r_buf[1] <= r_buf[0];
        r_buf[2] <= r_buf[1];
        r_buf[3] <= r_buf[2];
        if (r_fill != 3'd4) r_fill <= r_fill + 3'd1;
      end
      if (r_tick_d && r_fill == 3'd4) begin
        r_st       <= w_avg;
        r_st_valid <= 1'b1;
      end
    end
  end

  assign sfd      = r_out[0];
  assign srd      = r_out[1];
  assign sw       = r_out[2];
  assign sfa      = r_out[FA];
  assign evt      = r_evt;
  assign st       = r_st;
  assign st_valid = r_st_valid;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner at default parameters; expected values are
// hand-derived edge numbers and averages.
module tb_sensor_conditioner;
  logic       clk = 1'b0;
  logic       rst;
  logic       raw_fd, raw_rd, raw_w, raw_fa;
  logic [6:0] raw_st;
  logic       sfd, srd, sw, sfa, st_valid, evt;
  logic [6:0] st;

  int total = 0;
  int bad   = 0;

  sensor_conditioner #(.DEB_CYCLES(4), .SAMPLE_DIV(8)) dut (
    .clk(clk), .rst(rst),
    .raw_fd(raw_fd), .raw_rd(raw_rd), .raw_w(raw_w), .raw_fa(raw_fa), .raw_st(raw_st),
    .sfd(sfd), .srd(srd), .sw(sw), .sfa(sfa),
    .st(st), .st_valid(st_valid), .evt(evt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    raw_fd = 1'b1; raw_rd = 1'b1; raw_w = 1'b1; raw_fa = 1'b1;
    raw_st = 7'd100;
    for (int k = 0; k < 3; k++) step();
    total++;
    if ({sfd, srd, sw, sfa} !== 4'b0000) begin
      bad++; $display("FAIL reset_bin got %b want 0000", {sfd, srd, sw, sfa});
    end
    total++;
    if (st !== 7'd55) begin bad++; $display("FAIL reset_st got %0d want 55", st); end
    total++;
    if (st_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", st_valid); end
    total++;
    if (evt !== 1'b0) begin bad++; $display("FAIL reset_evt got %b want 0", evt); end
    raw_fd = 1'b0; raw_rd = 1'b0; raw_w = 1'b0; raw_fa = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 6; k++) step();
  endtask

  task automatic test_debounce();
    raw_fd = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      total++;
      if (sfd !== (k >= 6)) begin
        bad++; $display("FAIL deb_sfd edge %0d got %b want %b", k, sfd, (k >= 6));
      end
      total++;
      if (evt !== (k == 6)) begin
        bad++; $display("FAIL deb_evt edge %0d got %b want %b", k, evt, (k == 6));
      end
    end
    raw_fd = 1'b0;
    for (int k = 0; k < 3; k++) step();
    raw_fd = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      total++;
      if (sfd !== 1'b1 || evt !== 1'b0) begin
        bad++; $display("FAIL glitch edge %0d got sfd=%b evt=%b want sfd=1 evt=0", k, sfd, evt);
      end
    end
  endtask

  task automatic test_fire();
    logic exp_fa, exp_evt;
    raw_fa = 1'b1;
    step();
    raw_fa = 1'b0;
    total++;
    if (sfa !== 1'b0 || evt !== 1'b0) begin
      bad++; $display("FAIL fire edge 1 got sfa=%b evt=%b want 0 0", sfa, evt);
    end
    for (int k = 2; k <= 12; k++) begin
      step();
      exp_fa  = (k >= 3 && k < 7);
      exp_evt = (k == 3 || k == 7);
      total++;
      if (sfa !== exp_fa) begin
        bad++; $display("FAIL fire_sfa edge %0d got %b want %b", k, sfa, exp_fa);
      end
      total++;
      if (evt !== exp_evt) begin
        bad++; $display("FAIL fire_evt edge %0d got %b want %b", k, evt, exp_evt);
      end
    end
  endtask

  task automatic test_simultaneous();
    raw_rd = 1'b1; raw_w = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      total++;
      if (srd !== (k >= 6) || sw !== (k >= 6)) begin
        bad++; $display("FAIL simul_out edge %0d got srd=%b sw=%b want %b", k, srd, sw, (k >= 6));
      end
      total++;
      if (evt !== (k == 6)) begin
        bad++; $display("FAIL simul_evt edge %0d got %b want %b", k, evt, (k == 6));
      end
    end
    total++;
    if (sfd !== 1'b1) begin bad++; $display("FAIL simul_sfd got %b want 1", sfd); end
  endtask

  task automatic test_temperature();
    logic [6:0] vals [4];
    vals[0] = 7'd40; vals[1] = 7'd44; vals[2] = 7'd48; vals[3] = 7'd51;
    raw_fd = 1'b0; raw_rd = 1'b0; raw_w = 1'b0; raw_fa = 1'b0;
    rst = 1'b0;
    raw_st = vals[0];
    for (int k = 0; k < 3; k++) step();
    rst = 1'b1;
    for (int p = 0; p < 4; p++) begin
      raw_st = vals[p];
      for (int k = 1; k <= 8; k++) begin
        step();
        total++;
        if (st_valid !== 1'b0 || st !== 7'd55) begin
          bad++; $display("FAIL temp_early edge %0d got valid=%b st=%0d want 0 55", p*8+k, st_valid, st);
        end
      end
    end
    step();
    total++;
    if (st_valid !== 1'b1) begin bad++; $display("FAIL temp_valid edge 33 got %b want 1", st_valid); end
    total++;
    if (st !== 7'd45) begin bad++; $display("FAIL temp_avg edge 33 got %0d want 45", st); end
    raw_st = 7'd127;
    for (int k = 0; k < 7; k++) step();
    total++;
    if (st !== 7'd45) begin bad++; $display("FAIL temp_hold edge 40 got %0d want 45", st); end
    step();
    total++;
    if (st !== 7'd67) begin bad++; $display("FAIL temp_avg edge 41 got %0d want 67", st); end
    for (int k = 0; k < 8; k++) step();
    total++;
    if (st !== 7'd88) begin bad++; $display("FAIL temp_avg edge 49 got %0d want 88", st); end
    for (int k = 0; k < 8; k++) step();
    total++;
    if (st !== 7'd108) begin bad++; $display("FAIL temp_avg edge 57 got %0d want 108", st); end
    for (int k = 0; k < 8; k++) step();
    total++;
    if (st !== 7'd127 || st_valid !== 1'b1) begin
      bad++; $display("FAIL temp_max edge 65 got st=%0d valid=%b want 127 1", st, st_valid);
    end
  endtask

  task automatic test_reset_midfill();
    rst = 1'b0;
    raw_st = 7'd20;
    step();
    rst = 1'b1;
    for (int k = 0; k < 26; k++) step();
    rst = 1'b0;
    step();
    total++;
    if (st !== 7'd55 || st_valid !== 1'b0 || evt !== 1'b0) begin
      bad++; $display("FAIL midfill_reset got st=%0d valid=%b evt=%b want 55 0 0", st, st_valid, evt);
    end
    step();
    raw_st = 7'd60;
    rst = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      total++;
      if (st_valid !== 1'b0) begin
        bad++; $display("FAIL midfill_early edge %0d got valid=%b want 0", k, st_valid);
      end
    end
    step();
    total++;
    if (st_valid !== 1'b1 || st !== 7'd60) begin
      bad++; $display("FAIL midfill_valid edge 33 got valid=%b st=%0d want 1 60", st_valid, st);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_fire();
    test_simultaneous();
    test_temperature();
    test_reset_midfill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
